// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and display constants for the CPU run sequencer
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RESET   = 3'd2,
    ST_RUN     = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5,
    ST_TIMEOUT = 3'd6
  } run_state_t;

  // Shown on the 7-seg when the CPU never halted within its tick budget
  localparam logic [31:0] TIMEOUT_DISP = 32'hEEEE_EEEE;

endpackage

// File: rtl/run_tick_gen.sv
// rtl/run_tick_gen.sv - clock-enable pulse generator, one tick every CLK_DIV enabled cycles
module run_tick_gen #(
  parameter int CLK_DIV = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV);

  // Counts enabled cycles starting from 0 after a clear, so the first tick
  // lands CLK_DIV cycles after the enable begins; afterwards it cycles 1..CLK_DIV.
  logic [CW-1:0] r_cnt;

  // Divider counter: cleared by reset or clear, advances only while enabled
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == DIV_MAX) r_cnt <= CW'(1);
      else                  r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == DIV_MAX);

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - launches, paces and halt-detects the egg-drop CPU, then packs its results
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CLK_DIV     = 1000000,
  parameter int RST_CYCLES  = 4,
  parameter int HALT_STABLE = 8,
  parameter int MAX_TICKS   = 100000
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_start,
  input  logic [6:0]  in_floors_data,
  input  logic [6:0]  in_resistance_data,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_attempt,
  input  logic [31:0] cpu_broken,
  input  logic [31:0] cpu_human,
  input  logic [31:0] cpu_material,
  input  logic        cpu_is_last_broken,
  output logic        cpu_rst,
  output logic        cpu_tick,
  output logic [31:0] init_floors,
  output logic [31:0] init_resistance,
  output logic [31:0] o_disp_data,
  output logic        o_last_broken,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout
);

  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int HW = $clog2(HALT_STABLE) + 1;
  localparam int MW = $clog2(MAX_TICKS) + 1;
  localparam logic [RW-1:0] RC_MAX = RW'(RST_CYCLES);
  localparam logic [HW-1:0] HS_MAX = HW'(HALT_STABLE);
  localparam logic [MW-1:0] MT_MAX = MW'(MAX_TICKS);

  run_state_t    r_state, w_state_next;
  logic          r_sync1, r_sync2, r_sync_d;
  logic [6:0]    r_floors, r_resistance;
  logic [RW-1:0] r_rst_cnt;
  logic [HW-1:0] r_stable_cnt;
  logic [MW-1:0] r_run_cnt;
  logic [31:0]   r_last_pc;
  logic [7:0]    r_attempt, r_broken, r_material, r_human;
  logic          r_last_broken;

  logic          w_start_edge, w_tick;
  logic [RW-1:0] w_rst_next;
  logic [HW-1:0] w_stable_next;
  logic [MW-1:0] w_run_next;
  logic          w_unused_bits;

  // Only the low byte of each result word reaches the display
  assign w_unused_bits = ^{cpu_attempt[31:8], cpu_broken[31:8],
                           cpu_human[31:8], cpu_material[31:8]};

  assign w_start_edge = r_sync2 & ~r_sync_d;

  run_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .i_clk  (in_clk),
    .i_rst  (in_rst),
    .i_en   ((r_state == ST_RESET) || (r_state == ST_RUN)),
    .i_clr  (r_state == ST_LOAD),
    .o_tick (w_tick)
  );

  assign cpu_tick = w_tick;

  // Saturating counter increments; the PC-stable count restarts whenever the PC moves
  assign w_rst_next    = (r_rst_cnt == RC_MAX) ? r_rst_cnt : r_rst_cnt + RW'(1);
  assign w_run_next    = (r_run_cnt == MT_MAX) ? r_run_cnt : r_run_cnt + MW'(1);
  assign w_stable_next = (cpu_pc != r_last_pc)   ? '0 :
                         (r_stable_cnt == HS_MAX) ? r_stable_cnt : r_stable_cnt + HW'(1);

  // Start button: two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= in_start;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and state-decoded outputs; halt is tested before the budget so it wins a tie
  always_comb begin
    w_state_next = r_state;
    cpu_rst      = 1'b1;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_timeout    = 1'b0;
    o_disp_data  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy       = 1'b1;
        w_state_next = ST_RESET;
      end
      ST_RESET: begin
        o_busy = 1'b1;
        if (w_tick && (w_rst_next >= RC_MAX)) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        o_busy  = 1'b1;
        if (w_tick) begin
          if (w_stable_next >= HS_MAX)   w_state_next = ST_CAPTURE;
          else if (w_run_next >= MT_MAX) w_state_next = ST_TIMEOUT;
        end
      end
      ST_CAPTURE: begin
        cpu_rst      = 1'b0;
        o_busy       = 1'b1;
        w_state_next = ST_DONE;
      end
      ST_DONE: begin
        cpu_rst     = 1'b0;
        o_done      = 1'b1;
        o_disp_data = {r_attempt, r_broken, r_material, r_human};
        if (w_start_edge) w_state_next = ST_LOAD;
      end
      ST_TIMEOUT: begin
        o_timeout   = 1'b1;
        o_disp_data = TIMEOUT_DISP;
        if (w_start_edge) w_state_next = ST_LOAD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Launch values, pacing/halt counters and captured results
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_floors      <= '0;
      r_resistance  <= '0;
      r_rst_cnt     <= '0;
      r_stable_cnt  <= '0;
      r_run_cnt     <= '0;
      r_last_pc     <= '0;
      r_attempt     <= '0;
      r_broken      <= '0;
      r_material    <= '0;
      r_human       <= '0;
      r_last_broken <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_floors      <= in_floors_data;
          r_resistance  <= in_resistance_data;
          r_rst_cnt     <= '0;
          r_stable_cnt  <= '0;
          r_run_cnt     <= '0;
          r_last_pc     <= '0;
          r_attempt     <= '0;
          r_broken      <= '0;
          r_material    <= '0;
          r_human       <= '0;
          r_last_broken <= 1'b0;
        end
        ST_RESET: begin
          if (w_tick) r_rst_cnt <= w_rst_next;
        end
        ST_RUN: begin
          if (w_tick) begin
            r_stable_cnt <= w_stable_next;
            r_last_pc    <= cpu_pc;
            r_run_cnt    <= w_run_next;
          end
        end
        ST_CAPTURE: begin
          r_attempt     <= cpu_attempt[7:0];
          r_broken      <= cpu_broken[7:0];
          r_material    <= cpu_material[7:0];
          r_human       <= cpu_human[7:0];
          r_last_broken <= cpu_is_last_broken;
        end
        default: ;
      endcase
    end
  end

  assign init_floors     = {25'b0, r_floors};
  assign init_resistance = {25'b0, r_resistance};
  assign o_last_broken   = r_last_broken;

endmodule
